// File: rtl/iqmap_multi.sv
`default_nettype none
// ============================================================================
// Module   : iqmap_multi
// Purpose  : Mode-selectable Gray IQ mapper (QPSK/16QAM/64QAM) consuming
//            upstream words LSB-first with residual bits carried across words.
// Revision : 1.0
// ============================================================================
module iqmap_multi #(
    parameter int WORD_W = 128,
    parameter int OUT_W  = 11,
    parameter int SCALE  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ce,
    input  logic [1:0]        mode,
    input  logic              flush,
    input  logic              valid_i,
    input  logic [WORD_W-1:0] reader_data,
    output logic              reader_en,
    output logic [OUT_W-1:0]  xr,
    output logic [OUT_W-1:0]  xi,
    output logic              valid_o,
    output logic              valid_raw,
    output logic [5:0]        raw
);

    localparam int C_BUF_W  = 2 * WORD_W;
    localparam int C_FILL_W = $clog2(2 * WORD_W + 1);
    localparam logic [1:0]         C_MODE_16 = 2'd1;
    localparam logic [1:0]         C_MODE_64 = 2'd2;
    localparam logic [OUT_W-1:0]   C_SCALE   = OUT_W'(SCALE);
    localparam logic [C_FILL_W-1:0] C_WORD   = C_FILL_W'(WORD_W);

    logic [C_BUF_W-1:0]  r_buf;
    logic [C_FILL_W-1:0] r_fill;
    logic [1:0]          r_mode;

    logic [C_FILL_W-1:0] w_k;
    logic                w_emit;
    logic                w_acc;
    logic [C_BUF_W-1:0]  w_shifted;
    logic [C_FILL_W-1:0] w_fill_sh;
    logic [C_BUF_W-1:0]  w_buf_next;
    logic [C_FILL_W-1:0] w_fill_next;
    logic [5:0]          w_raw;
    logic [OUT_W-1:0]    w_xr;
    logic [OUT_W-1:0]    w_xi;

    // Sign comes from the first bit of the axis group; the remaining bits
    // are Gray-decoded into a magnitude index counted down from the outer ring.
    function automatic logic [OUT_W-1:0] level(input logic [1:0] m, input logic b_s,
                                               input logic b_m, input logic b_l);
        logic [2:0]       mag;
        logic [OUT_W-1:0] amp;
        case (m)
            C_MODE_16: mag = b_m ? 3'd1 : 3'd3;
            C_MODE_64: mag = 3'd7 - {b_m, b_m ^ b_l, 1'b0};
            default:   mag = 3'd1;
        endcase
        amp = OUT_W'(mag) * C_SCALE;
        return b_s ? -amp : amp;
    endfunction

    always_comb begin
        case (r_mode)
            C_MODE_16: begin
                w_k   = C_FILL_W'(4);
                w_raw = {2'b00, r_buf[3:0]};
            end
            C_MODE_64: begin
                w_k   = C_FILL_W'(6);
                w_raw = r_buf[5:0];
            end
            default: begin
                w_k   = C_FILL_W'(2);
                w_raw = {4'b0000, r_buf[1:0]};
            end
        endcase
        w_emit    = ce & ~flush & (r_fill >= w_k);
        w_acc     = ce & ~flush & valid_i & reader_en;
        w_shifted = w_emit ? (r_buf >> w_k) : r_buf;
        w_fill_sh = w_emit ? (r_fill - w_k) : r_fill;
        // New word lands directly above whatever survives this cycle's shift.
        w_buf_next  = w_acc ? (w_shifted | ({{WORD_W{1'b0}}, reader_data} << w_fill_sh))
                            : w_shifted;
        w_fill_next = w_acc ? (w_fill_sh + C_WORD) : w_fill_sh;
        w_xr = level(r_mode, r_buf[0], r_buf[2], r_buf[4]);
        w_xi = level(r_mode, r_buf[1], r_buf[3], r_buf[5]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_buf     <= '0;
            r_fill    <= '0;
            r_mode    <= 2'd0;
            reader_en <= 1'b1;
            xr        <= '0;
            xi        <= '0;
            raw       <= '0;
            valid_o   <= 1'b0;
        end else begin
            if (r_fill == '0) begin
                r_mode <= mode;
            end
            if (flush) begin
                r_buf     <= '0;
                r_fill    <= '0;
                reader_en <= 1'b0;
            end else begin
                r_buf     <= w_buf_next;
                r_fill    <= w_fill_next;
                reader_en <= (w_fill_next <= C_WORD);
            end
            valid_o <= w_emit;
            if (w_emit) begin
                xr  <= w_xr;
                xi  <= w_xi;
                raw <= w_raw;
            end
        end
    end

    assign valid_raw = valid_o;

endmodule
`default_nettype wire

// File: tb/tb_iqmap_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_iqmap_multi
// Purpose  : Scoreboard bench for iqmap_multi (QPSK/16QAM/64QAM, ce, flush,
//            asynchronous reset).
// Revision : 1.0
// ============================================================================
module tb_iqmap_multi;

    localparam int WORD_W = 128;
    localparam int OUT_W  = 11;
    localparam int SCALE  = 1;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              ce = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              flush = 1'b0;
    logic              valid_i = 1'b0;
    logic [WORD_W-1:0] reader_data = '0;
    logic              reader_en;
    logic [OUT_W-1:0]  xr;
    logic [OUT_W-1:0]  xi;
    logic              valid_o;
    logic              valid_raw;
    logic [5:0]        raw;

    iqmap_multi #(.WORD_W(WORD_W), .OUT_W(OUT_W), .SCALE(SCALE)) dut (
        .CLK(CLK), .RST(RST), .ce(ce), .mode(mode), .flush(flush),
        .valid_i(valid_i), .reader_data(reader_data), .reader_en(reader_en),
        .xr(xr), .xi(xi), .valid_o(valid_o), .valid_raw(valid_raw), .raw(raw)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [27:0] exp_q[$];
    bit          mq[$];
    logic [1:0]  m_mode = 2'd0;
    int          m_fill = 0;
    int          n_valid = 0;
    int          run_len = 0;
    int          last_run = 0;
    logic [5:0]  rec_raw [0:255];
    logic [21:0] rec_xy  [0:255];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ksz(input logic [1:0] m);
        return (m == 2'd1) ? 4 : (m == 2'd2) ? 6 : 2;
    endfunction

    // g = {sign bit, middle bit, low bit} of one axis, in ISDB-T order
    function automatic int lvl(input logic [1:0] m, input logic [2:0] g);
        if (m == 2'd1) begin
            case (g[2:1])
                2'b00: return 3;
                2'b01: return 1;
                2'b11: return -1;
                default: return -3;
            endcase
        end else if (m == 2'd2) begin
            case (g)
                3'b000: return 7;
                3'b001: return 5;
                3'b011: return 3;
                3'b010: return 1;
                3'b110: return -1;
                3'b111: return -3;
                3'b101: return -5;
                default: return -7;
            endcase
        end
        return g[2] ? -1 : 1;
    endfunction

    function automatic logic [27:0] exp_sym(input logic [1:0] m, input logic [5:0] b);
        logic [OUT_W-1:0] il;
        logic [OUT_W-1:0] ql;
        il = OUT_W'(lvl(m, {b[0], b[2], b[4]}) * SCALE);
        ql = OUT_W'(lvl(m, {b[1], b[3], b[5]}) * SCALE);
        return {b, il, ql};
    endfunction

    // Reference model on the rising edge, output monitor on the falling edge.
    always @(posedge CLK or negedge CLK or posedge RST) begin
        if (RST) begin
            exp_q.delete();
            mq.delete();
            m_mode  = 2'd0;
            m_fill  = 0;
            run_len = 0;
        end else if (CLK) begin
            int k;
            k = ksz(m_mode);
            if (m_fill == 0) m_mode = mode;
            if (flush) begin
                m_fill = 0;
                mq.delete();
                exp_q.delete();
            end else begin
                if (ce && m_fill >= k) m_fill -= k;
                if (ce && valid_i && reader_en) begin
                    m_fill += WORD_W;
                    for (int i = 0; i < WORD_W; i++) mq.push_back(reader_data[i]);
                    k = ksz(m_mode);
                    while (mq.size() >= k) begin
                        logic [5:0] b;
                        b = '0;
                        for (int j = 0; j < k; j++) b[j] = mq.pop_front();
                        exp_q.push_back(exp_sym(m_mode, b));
                    end
                end
            end
        end else begin
            if (valid_o) begin
                rec_raw[n_valid % 256] = raw;
                rec_xy[n_valid % 256]  = {xr, xi};
                n_valid++;
                run_len++;
                if (exp_q.size() == 0) check("unexpected_symbol", {4'b0, raw, xr, xi}, 32'hFFFF_FFFF);
                else check("symbol", {4'b0, raw, xr, xi}, {4'b0, exp_q.pop_front()});
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        bit done;
        done = 1'b0;
        reader_data = w;
        valid_i = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (reader_en && ce) done = 1'b1;
            tick();
        end
        if (!done) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (exp_q.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) check("drain_timeout", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    function automatic logic [WORD_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [WORD_W-1:0] w0, w1, w2;

        #1 RST = 1'b1;
        #1;
        check("rst_xr", 32'(xr), 32'd0);
        check("rst_xi", 32'(xi), 32'd0);
        check("rst_raw", 32'(raw), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(reader_en), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        ce = 1'b1;
        tick();

        // 16QAM directed word, latency and run length
        mode = 2'd1;
        tick();
        base = n_valid;
        reader_data = {104'b0, 24'hF43210};
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("q16_lat0", 32'(valid_o), 32'd0);
        tick();
        check("q16_lat1", 32'(valid_o), 32'd1);
        check("q16_valid_raw", 32'(valid_raw), 32'd1);
        check("q16_first", 32'({xr, xi}), 32'({11'd3, 11'd3}));
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 31; i++) begin
                tick();
                if (valid_o) cnt++;
            end
            check("q16_consecutive", 32'(cnt), 32'd31);
        end
        wait_drain();
        check("q16_count", 32'(n_valid - base), 32'd32);

        // QPSK all-ones, back-to-back words
        mode = 2'd0;
        tick();
        base = n_valid;
        for (int i = 0; i < 3; i++) send_word('1);
        valid_i = 1'b0;
        wait_drain();
        check("qpsk_count", 32'(n_valid - base), 32'd192);
        check("qpsk_gapless", 32'(last_run), 32'd192);

        // 64QAM, three words pack into exactly 64 symbols
        mode = 2'd2;
        tick();
        base = n_valid;
        w0 = rnd_word();
        w0[11:0] = 12'hFC0;
        w1 = rnd_word();
        w2 = rnd_word();
        send_word(w0);
        send_word(w1);
        send_word(w2);
        valid_i = 1'b0;
        wait_drain();
        check("q64_count", 32'(n_valid - base), 32'd64);
        check("q64_gapless", 32'(last_run), 32'd64);
        check("q64_sym21_raw", 32'(rec_raw[(base + 21) % 256]), 32'({w1[3:0], w0[127:126]}));
        check("q64_zeros", 32'(rec_xy[base % 256]), 32'({11'd7, 11'd7}));
        check("q64_ones", 32'(rec_xy[(base + 1) % 256]), 32'({11'h7FD, 11'h7FD}));

        // ce held low mid-stream
        mode = 2'd1;
        tick();
        base = n_valid;
        send_word(rnd_word());
        valid_i = 1'b0;
        repeat (10) tick();
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ce_low_valid", 32'(valid_o), 32'd0);
        end
        ce = 1'b1;
        wait_drain();
        check("ce_count", 32'(n_valid - base), 32'd32);

        // flush drops buffer and the concurrent word; next word maps as 64QAM
        base = n_valid;
        send_word(rnd_word());
        valid_i = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        mode = 2'd2;
        valid_i = 1'b1;
        reader_data = rnd_word();
        tick();
        flush = 1'b0;
        valid_i = 1'b0;
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_ready", 32'(reader_en), 32'd0);
        check("flush_count", 32'(n_valid - base), 32'd3);
        tick();
        base = n_valid;
        send_word(rnd_word());
        valid_i = 1'b0;
        wait_drain();
        check("flush_q64_count", 32'(n_valid - base), 32'd21);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        // asynchronous reset in the middle of a QPSK burst
        mode = 2'd0;
        tick();
        send_word(rnd_word());
        valid_i = 1'b0;
        repeat (4) tick();
        #3 RST = 1'b1;
        #1;
        check("arst_xr", 32'(xr), 32'd0);
        check("arst_xi", 32'(xi), 32'd0);
        check("arst_raw", 32'(raw), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_ready", 32'(reader_en), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) tick();
        check("post_rst_valid", 32'(valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
